// File: rtl/i2c_slave_regs.sv
// I2C slave exposing four 8-bit registers behind a 2-bit register pointer.
// Master writes: address, pointer byte, then data bytes into reg[ptr].
// Master reads: address with R/W=1, then reg[ptr] bytes until master NACK.
// SCL/SDA are oversampled on clk through 2-FF synchronizers.
// Build option: define I2C_SLAVE_AUTOINC_EN to advance ptr (mod 4) after every
// data byte written or read; otherwise ptr only changes on a pointer byte.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1010101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [31:0] regs_out,
  output logic        wr_stb,
  output logic [1:0]  wr_addr,
  output logic        busy
);

`ifdef I2C_SLAVE_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
    StWdata, StWdataAck, StRdata, StRdataAck, StIgnore
  } state_e;

  // Synchronizer and edge-detect stages
  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [31:0] regs_q, regs_d;
  logic        mack_q, mack_d;
  logic        sda_oe_q, sda_oe_d;
  logic        wr_stb_q, wr_stb_d;
  logic [1:0]  wr_addr_q, wr_addr_d;
  logic        busy_q, busy_d;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] shift_in, cur_byte;

  assign scl_rise  = scl_sync_q & ~scl_prev_q;
  assign scl_fall  = ~scl_sync_q & scl_prev_q;
  assign start_det = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
  assign stop_det  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
  assign shift_in  = {shift_q[6:0], sda_sync_q};
  assign cur_byte  = regs_q[{ptr_q, 3'b000} +: 8];

  // Next-state logic: bus conditions first, then per-state bit handling
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    regs_d    = regs_q;
    mack_d    = mack_q;
    sda_oe_d  = sda_oe_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    busy_d    = busy_q;

    if (stop_det) begin
      state_d   = StIdle;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (start_det) begin
      state_d   = StAddr;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      unique case (state_q)
        StAddr, StPtr, StWdata: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == StPtr) ptr_d = shift_in[1:0];
              if (state_q == StWdata) begin
                regs_d[{ptr_q, 3'b000} +: 8] = shift_in;
                wr_stb_d  = 1'b1;
                wr_addr_d = ptr_q;
                if (AutoInc) ptr_d = ptr_q + 2'd1;
              end
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (state_q == StAddr) begin
              // Address 0 (general call) is never acknowledged
              if (shift_q[7:1] == SLAVE_ADDR && shift_q[7:1] != 7'd0) begin
                state_d  = StAddrAck;
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
              end else begin
                state_d  = StIgnore;
                sda_oe_d = 1'b0;
                busy_d   = 1'b0;
              end
            end else begin
              state_d  = (state_q == StPtr) ? StPtrAck : StWdataAck;
              sda_oe_d = 1'b1;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (shift_q[0]) begin
              // Snapshot the byte so later writes cannot disturb it
              state_d  = StRdata;
              tx_d     = cur_byte;
              sda_oe_d = ~cur_byte[7];
            end else begin
              state_d  = StPtr;
              sda_oe_d = 1'b0;
            end
          end
        end
        StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            state_d   = StWdata;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
          end
        end
        StRdata: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7 && AutoInc) ptr_d = ptr_q + 2'd1;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            if (bit_cnt_q == 4'd8) begin
              state_d  = StRdataAck;
              sda_oe_d = 1'b0;
            end else begin
              tx_d     = {tx_q[6:0], 1'b0};
              sda_oe_d = ~tx_q[6];
            end
          end
        end
        StRdataAck: begin
          if (scl_rise) begin
            mack_d = sda_sync_q;
          end else if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (!mack_q) begin
              state_d  = StRdata;
              tx_d     = cur_byte;
              sda_oe_d = ~cur_byte[7];
            end else begin
              state_d  = StIgnore;
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
            end
          end
        end
        StIdle, StIgnore: ;
        default: state_d = StIdle;
      endcase
    end
  end

  // State, synchronizer and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= StIdle;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      tx_q       <= 8'd0;
      ptr_q      <= 2'd0;
      regs_q     <= 32'h0000_0000;
      mack_q     <= 1'b1;
      sda_oe_q   <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= 2'd0;
      busy_q     <= 1'b0;
    end else begin
      scl_meta_q <= scl_in;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      regs_q     <= regs_d;
      mack_q     <= mack_d;
      sda_oe_q   <= sda_oe_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      busy_q     <= busy_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign regs_out = regs_q;
  assign wr_stb   = wr_stb_q;
  assign wr_addr  = wr_addr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-banged I2C master, register/pointer model,
// directed bus scenarios followed by randomized write/read/foreign-address traffic.
module tb_i2c_slave_regs;

  localparam logic [6:0] SA = 7'h55;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_oe;
  logic [31:0] regs_out;
  logic        wr_stb;
  logic [1:0]  wr_addr;
  logic        busy;
  wire         sda_line = sda_m & ~sda_oe;

  i2c_slave_regs #(.SLAVE_ADDR(SA)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_m),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .regs_out (regs_out),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [7:0] mregs[4];
  logic [1:0] mptr;
  logic [9:0] exp_log[$];
  logic [9:0] got_log[$];

  function automatic logic [31:0] model_regs();
    return {mregs[3], mregs[2], mregs[1], mregs[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
    mptr = 2'd0;
  endtask

  task automatic model_write(input logic [7:0] d);
    mregs[mptr] = d;
    exp_log.push_back({mptr, d});
`ifdef I2C_SLAVE_AUTOINC_EN
    mptr = mptr + 2'd1;
`endif
  endtask

  task automatic model_read_done();
`ifdef I2C_SLAVE_AUTOINC_EN
    mptr = mptr + 2'd1;
`endif
  endtask

  // Write-strobe monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (wr_stb) got_log.push_back({wr_addr, regs_out[{wr_addr, 3'b000} +: 8]});
  end

  // Bus-level master primitives
  task automatic wq();
    repeat (5) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b; wq();
    scl_m = 1'b1; wq();
    s = sda_line; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(nack, s);
  endtask

  // Compare regs and strobe log against the model, then clear logs
  task automatic end_txn(input string tag);
    check_eq({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_regs"}, regs_out, model_regs());
    check_eq({tag, "_stb_cnt"}, got_log.size(), exp_log.size());
    if (got_log.size() == exp_log.size())
      foreach (exp_log[i]) check_eq({tag, "_stb"}, {22'd0, got_log[i]}, {22'd0, exp_log[i]});
    got_log.delete();
    exp_log.delete();
  endtask

  task automatic do_write(input string tag, input logic [7:0] p, input int n,
                          input logic [31:0] data);
    logic ack;
    i2c_start();
    send_byte({SA, 1'b0}, ack);
    check_eq({tag, "_addr_ack"}, {31'd0, ack}, 32'd1);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
    send_byte(p, ack);
    check_eq({tag, "_ptr_ack"}, {31'd0, ack}, 32'd1);
    mptr = p[1:0];
    for (int i = 0; i < n; i++) begin
      send_byte(data[i*8 +: 8], ack);
      check_eq({tag, "_data_ack"}, {31'd0, ack}, 32'd1);
      model_write(data[i*8 +: 8]);
    end
    i2c_stop();
    wq();
    end_txn(tag);
  endtask

  task automatic do_read(input string tag, input int n);
    logic       ack;
    logic [7:0] d;
    i2c_start();
    send_byte({SA, 1'b1}, ack);
    check_eq({tag, "_raddr_ack"}, {31'd0, ack}, 32'd1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, d);
      check_eq({tag, "_rdata"}, {24'd0, d}, {24'd0, mregs[mptr]});
      model_read_done();
    end
    check_eq({tag, "_rel"}, {31'd0, sda_oe}, 32'd0);
    i2c_stop();
    wq();
    end_txn(tag);
  endtask

  task automatic do_foreign(input string tag, input logic [6:0] a);
    logic ack;
    i2c_start();
    send_byte({a, 1'($urandom_range(0, 1))}, ack);
    check_eq({tag, "_nack"}, {31'd0, ack}, 32'd0);
    check_eq({tag, "_busy0"}, {31'd0, busy}, 32'd0);
    send_byte(8'($urandom), ack);
    check_eq({tag, "_ign"}, {31'd0, ack}, 32'd0);
    i2c_stop();
    wq();
    end_txn(tag);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack, s;
    logic [7:0] d;
    logic [6:0] a;

    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_regs", regs_out, 32'h0);
    check_eq("rst_oe_busy_stb", {29'd0, sda_oe, busy, wr_stb}, 32'd0);
    check_eq("rst_wr_addr", {30'd0, wr_addr}, 32'd0);
    wq();

    // Basic write to reg1
    do_write("w5c", 8'h01, 1, 32'h0000_005C);
    check_eq("w5c_val", regs_out, 32'h0000_5C00);

    // Foreign address 0x54
    do_foreign("a54", 7'h54);
    // General call
    do_foreign("gc", 7'h00);

    // Wrap-around from reg3 (autoinc) or repeated target (no autoinc)
    do_write("wrap", 8'h03, 2, 32'h0000_2211);

    // Repeated-start read from reg1
    i2c_start();
    send_byte({SA, 1'b0}, ack);
    send_byte(8'h01, ack);
    mptr = 2'd1;
    i2c_start();
    send_byte({SA, 1'b1}, ack);
    check_eq("sr_ack", {31'd0, ack}, 32'd1);
    recv_byte(1'b1, d);
    check_eq("sr_data", {24'd0, d}, 32'h5C);
    model_read_done();
    check_eq("sr_oe", {31'd0, sda_oe}, 32'd0);
    check_eq("sr_busy", {31'd0, busy}, 32'd0);
    i2c_stop();
    wq();
    end_txn("sr");

    // STOP after 3 bits of a data byte
    i2c_start();
    send_byte({SA, 1'b0}, ack);
    send_byte(8'h02, ack);
    mptr = 2'd2;
    for (int i = 0; i < 3; i++) clk_bit(1'b1, s);
    i2c_stop();
    wq();
    end_txn("stop3");

    // Reset while slave drives a read byte (reg0 = 0x0F, bit4 = 0)
    do_write("pre", 8'h00, 1, 32'h0000_000F);
    mptr = 2'd0;
    i2c_start();
    send_byte({SA, 1'b1}, ack);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, s);
    check_eq("rd_pull", {31'd0, sda_oe}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rd_rst_oe", {31'd0, sda_oe}, 32'd0);
    model_reset();
    for (int i = 0; i < 6; i++) clk_bit(1'b1, s);
    i2c_stop();
    wq();
    end_txn("rd_rst");

    // Reset in the middle of a write data byte
    do_write("pre2", 8'h02, 1, 32'h0000_00A5);
    i2c_start();
    send_byte({SA, 1'b0}, ack);
    send_byte(8'h01, ack);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, s);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("wr_rst_oe", {31'd0, sda_oe}, 32'd0);
    model_reset();
    for (int i = 0; i < 5; i++) clk_bit(1'b1, s);
    i2c_stop();
    wq();
    end_txn("wr_rst");

    // Randomized traffic
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 2))
        0: do_write("rw", 8'($urandom), int'($urandom_range(1, 3)), $urandom);
        1: do_read("rr", int'($urandom_range(1, 3)));
        default: begin
          a = 7'($urandom);
          if (a == SA) a = 7'h00;
          do_foreign("rf", a);
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
